// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared constants and helpers for the dynamic direction predictor.
//   - predict_o codes driven toward the PC-select logic
//   - 2-bit saturating counter encodings and their reset value
//   - cnt_train(): saturating counter update used by the table write port
// Optional feature macro used by the design: BP_GSHARE_EN (see branch_predictor).
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

   // Prediction codes
   localparam logic [1:0] PRED_NONE   = 2'b00;
   localparam logic [1:0] PRED_TAKEN  = 2'b10;
   localparam logic [1:0] PRED_NTAKEN = 2'b01;

   // Counter states: bit 1 set means "predict taken"
   localparam logic [1:0] CNT_SNT   = 2'b00;
   localparam logic [1:0] CNT_WNT   = 2'b01;
   localparam logic [1:0] CNT_WT    = 2'b10;
   localparam logic [1:0] CNT_ST    = 2'b11;
   localparam logic [1:0] CNT_RESET = CNT_WNT;

   // Move one step toward the resolved direction, sticking at the ends.
   function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      res = cnt;
      if (taken) begin
         if (cnt != CNT_ST) res = cnt + 2'd1;
      end else begin
         if (cnt != CNT_SNT) res = cnt - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// -----------------------------------------------------------------------------
// bp_table
// ENTRIES x 2-bit saturating counter array with one combinational read port
// and one saturating-update write port. All counters reset to weak-not-taken.
// Ports:
//   clk         core clock
//   rst         asynchronous active-low reset
//   rd_idx_i    read index
//   rd_cnt_o    counter at rd_idx_i (pre-update value during a same-cycle write)
//   wr_en_i     train the counter at wr_idx_i on this clock edge
//   wr_idx_i    write index
//   wr_taken_i  resolved direction: 1 increments, 0 decrements
// -----------------------------------------------------------------------------
module bp_table
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 32,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [1:0]       rd_cnt_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   logic [1:0] cnt_vec [ENTRIES];

   // One register per entry so each counter has its own reset and write enable.
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic [1:0] cnt_q;
         logic [1:0] cnt_d;
         logic       hit;

         assign hit = wr_en_i && (wr_idx_i == IDX_W'(gi));

         always_comb begin
            cnt_d = cnt_q;
            if (hit) cnt_d = cnt_train(cnt_q, wr_taken_i);
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt_q <= CNT_RESET;
            else      cnt_q <= cnt_d;
         end

         assign cnt_vec[gi] = cnt_q;
      end
   endgenerate

   // Read returns the stored value; a write in the same cycle shows up next cycle.
   assign rd_cnt_o = cnt_vec[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Dynamic 2-bit-counter direction predictor for the 3-stage RISC-V core.
// Looks up the decode-stage branch, remembers that lookup for one cycle and
// trains the same entry when the branch resolves in execute.
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   stall_i             freezes pending lookup, training and lookup counting
//   flush_i             decode instruction squashed this cycle
//   pc_i, is_branch_i   decode-stage PC and conditional-branch flag
//   predict_o           00 none, 10 taken, 01 not-taken (combinational)
//   br_resolve_i        execute-stage branch resolved this cycle
//   br_taken_i          resolved direction
//   mispredict_o        resolved direction differs from the stored prediction
//   stat_clr_i          synchronous clear of both statistics counters
//   lookup_cnt_o        number of valid lookups (wraps at 2^32)
//   mispredict_cnt_o    number of mispredicts (wraps at 2^32)
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// the lookup index (gshare). Port list is identical either way.
// -----------------------------------------------------------------------------
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic        is_branch_i,
   output logic [1:0]  predict_o,
   input  logic        br_resolve_i,
   input  logic        br_taken_i,
   output logic        mispredict_o,
   input  logic        stat_clr_i,
   output logic [31:0] lookup_cnt_o,
   output logic [31:0] mispredict_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [IDX_W-1:0] pc_idx;
   logic [IDX_W-1:0] look_idx;
   logic [1:0]       rd_cnt;
   logic             look_taken;
   logic             lookup_valid;
   logic             res_valid;

   logic             pend_valid_q, pend_valid_d;
   logic [IDX_W-1:0] pend_idx_q,   pend_idx_d;
   logic             pend_pred_q,  pend_pred_d;

   logic [31:0]      lookup_cnt_q, lookup_cnt_d;
   logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

   // Only the word-index bits of the PC feed the table.
   logic unused_bits;
   assign unused_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0], rd_cnt[0]};

   assign pc_idx = pc_i[IDX_W+1:2];

`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   assign look_idx = pc_idx ^ ghr_q;

   // History shifts in each trained outcome, youngest in bit 0.
   always_comb begin
      ghr_d = ghr_q;
      if (res_valid) ghr_d = {ghr_q[IDX_W-2:0], br_taken_i};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr_q <= '0;
      else      ghr_q <= ghr_d;
   end
`else
   assign look_idx = pc_idx;
`endif

   bp_table #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_table (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (look_idx),
      .rd_cnt_o   (rd_cnt),
      .wr_en_i    (res_valid),
      .wr_idx_i   (pend_idx_q),
      .wr_taken_i (br_taken_i)
   );

   assign look_taken   = rd_cnt[1];
   assign lookup_valid = is_branch_i & ~flush_i;

   always_comb begin
      predict_o = PRED_NONE;
      if (lookup_valid) predict_o = look_taken ? PRED_TAKEN : PRED_NTAKEN;
   end

   // A resolve only counts when it pairs with a lookup we actually recorded.
   assign res_valid    = br_resolve_i & pend_valid_q & ~stall_i;
   assign mispredict_o = res_valid & (br_taken_i != pend_pred_q);

   // Pending lookup: stores the (possibly hashed) index so training hits the
   // entry that was read.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_idx_d   = pend_idx_q;
      pend_pred_d  = pend_pred_q;
      if (!stall_i) begin
         pend_valid_d = lookup_valid;
         pend_idx_d   = look_idx;
         pend_pred_d  = look_taken;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
         pend_pred_q  <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
         pend_pred_q  <= pend_pred_d;
      end
   end

   // Statistics: clear wins over any increment in the same cycle.
   always_comb begin
      lookup_cnt_d     = lookup_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (stat_clr_i) begin
         lookup_cnt_d     = '0;
         mispredict_cnt_d = '0;
      end else begin
         if (lookup_valid && !stall_i) lookup_cnt_d = lookup_cnt_q + 32'd1;
         if (mispredict_o)             mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lookup_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         lookup_cnt_q     <= lookup_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign lookup_cnt_o     = lookup_cnt_q;
   assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic direction predictor for the 3-stage RISC-V core.
- Looks up a table of 2-bit saturating counters for the conditional branch in decode, and drives the 2-bit prediction code consumed by the PC-select logic.
- Keeps the lookup for one cycle and trains the counter when the branch resolves in execute.
- Exposes lookup and mispredict statistics for CSR readout.

Parameters:
- ENTRIES, 32, number of counters; power of two, at least 4.
- IDX_W, $clog2(ENTRIES), table index width (derived; not overridden).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  pipeline stall; freezes predictor state
- flush_i  in  1  decode instruction squashed this cycle
- pc_i  in  32  PC of instruction in decode
- is_branch_i  in  1  decode instruction is a conditional branch
- predict_o  out  2  00 = no branch, 10 = predict taken, 01 = predict not-taken
- br_resolve_i  in  1  execute-stage branch resolved this cycle
- br_taken_i  in  1  resolved direction
- mispredict_o  out  1  resolved direction differs from stored prediction
- stat_clr_i  in  1  synchronous clear of statistics
- lookup_cnt_o  out  32  count of valid lookups
- mispredict_cnt_o  out  32  count of mispredicts

Behaviour:
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is taken when counter bit 1 is set.
- Index: idx = pc_i[IDX_W+1:2].
- predict_o is combinational from the table in the same cycle.
  - It is 00 when is_branch_i = 0 or flush_i = 1.
  - Otherwise it is 10 or 01 from the counter.
- Pending register (pend_valid, pend_idx, pend_pred) updates on each clk edge with stall_i = 0:
  - pend_valid <= is_branch_i & ~flush_i.
  - pend_idx and pend_pred are captured from the current lookup.
  - It holds while stall_i = 1.
- Resolution: the update is valid when br_resolve_i & pend_valid & ~stall_i.
  - Taken increments the counter at pend_idx, saturating at 11.
  - Not-taken decrements it, saturating at 00.
  - The write lands at the clock edge.
- br_resolve_i with pend_valid = 0 is ignored: no update, no count, and mispredict_o = 0.
- mispredict_o is combinational: resolve-valid & (br_taken_i != pend_pred).
- Same-cycle lookup and update to the same index: the lookup returns the pre-update counter (read-before-write). The new value is visible from the next cycle.
- Statistics:
  - lookup_cnt increments on is_branch_i & ~flush_i & ~stall_i.
  - mispredict_cnt increments when mispredict_o = 1.
  - Both are 32-bit and wrap to 0 at 2^32.
  - stat_clr_i zeroes both and takes priority over any increment in the same cycle.
- Reset (asynchronous, any time, including mid-resolve):
  - All counters go to 01; pend_valid = 0; both stat counters go to 0; the history register goes to 0.
  - predict_o follows the rule above combinationally; mispredict_o = 0.
  - The first edge after deassertion behaves as normal operation.
- Latency: prediction 0 cycles; training visible 1 cycle after the resolve edge.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register ghr.
  - Lookup index = pc_i[IDX_W+1:2] ^ ghr.
  - On each valid resolution, ghr <= {ghr[IDX_W-2:0], br_taken_i}.
  - pend_idx stores the XORed index, so training hits the entry that was read.
- Not defined: no ghr; plain PC indexing; identical port list.

Decomposition:
- Shared package holds:
  - predict_o codes PRED_NONE = 2'b00, PRED_TAKEN = 2'b10, PRED_NTAKEN = 2'b01.
  - counter constants CNT_SNT/WNT/WT/ST and the reset value CNT_WNT.
- One sub-module, bp_table:
  - ENTRIES x 2-bit flop array with asynchronous active-low reset.
  - One combinational read port and one saturating-update write port.
- Index hashing, the pending register and the statistics stay in the top level.

Test Plan:
- Reset, then pc_i = 0x100 with is_branch_i = 1 -> predict_o = 01; lookup_cnt_o = 1 after the edge.
- Same PC, two consecutive resolves taken -> counter goes 01->10->11; the next lookup returns 10. The first resolve raises mispredict_o and mispredict_cnt_o = 1; the second does not.
- Counter at 11, resolve taken three more times -> stays 11. Counter at 00, resolve not-taken -> stays 00.
- flush_i = 1 with is_branch_i = 1 -> predict_o = 00. The next-cycle br_resolve_i is ignored: no counter change, no counts.
- stall_i = 1 for 3 cycles between lookup and resolve -> pending state is held; training occurs on the first unstalled resolve. Also: stat_clr_i together with a mispredict -> both counts read 0.
- Drop rst low mid-resolve -> table reads 01 everywhere, counts are 0, and mispredict_o = 0. With BP_GSHARE_EN, after three taken resolves ghr = 3'b111 (for ENTRIES = 8), and pc 0x104 indexes entry 1^7 = 6.
